// File: rtl/regfile_dump.sv
// Three-port register file (R0-R14 stored, R15 supplied externally) with a
// handshaked serial dump engine that streams a snapshot of all 16 registers.
module regfile_dump #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [3:0]       wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [3:0]       dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  logic [WIDTH-1:0] regs_r [0:NREG-2];
  state_t           state_r;
  logic [3:0]       idx_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;

  // Register storage: clear on reset, otherwise accept port-3 writes except to R15.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we3 && (wa3 != 4'd15)) begin
      regs_r[wa3] <= wd3;
    end
  end

  // Reads see the stored array directly, so a write only shows up after its edge.
  assign rd1 = (ra1 == 4'd15) ? r15 : regs_r[ra1];
  assign rd2 = (ra2 == 4'd15) ? r15 : regs_r[ra2];

  // Dump sequencer: LOAD snapshots one register, SEND holds it until accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      data_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (dump_start) begin
            state_r <= LOAD;
            idx_r   <= 4'd0;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          // Nonblocking read of regs_r yields the pre-write value on a same-edge write.
          data_r  <= (idx_r == 4'd15) ? r15 : regs_r[idx_r];
          valid_r <= 1'b1;
          state_r <= SEND;
        end
        SEND: begin
          if (dump_ready) begin
            valid_r <= 1'b0;
            if (idx_r == 4'd15) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              idx_r   <= idx_r + 4'd1;
              state_r <= LOAD;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = valid_r;
  assign dump_idx   = idx_r;
  assign dump_data  = data_r;
  assign dump_busy  = busy_r;
  assign dump_done  = done_r;

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter NREG, default 16, register count; fixed at 16 (4-bit addresses), R15 not stored.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 we3  input  1  write enable for write port 3.
REQ-006 wa3  input  4  write address.
REQ-007 wd3  input  WIDTH  write data.
REQ-008 ra1  input  4  read address, port 1.
REQ-009 ra2  input  4  read address, port 2.
REQ-010 r15  input  WIDTH  externally supplied R15 value (PC+8).
REQ-011 rd1  output  WIDTH  read data, port 1.
REQ-012 rd2  output  WIDTH  read data, port 2.
REQ-013 dump_start  input  1  request a serial read-out of all 16 registers.
REQ-014 dump_ready  input  1  consumer accepts the current dump beat.
REQ-015 dump_valid  output  1  dump_data/dump_idx hold a valid beat.
REQ-016 dump_idx  output  4  register index of current beat.
REQ-017 dump_data  output  WIDTH  captured register value for current beat.
REQ-018 dump_busy  output  1  dump sequence in progress (any state except IDLE).
REQ-019 dump_done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-020 Storage: R0-R14, WIDTH bits each; R15 never stored.
REQ-021 Write: at rising edge with reset high, we3=1 and wa3!=15 -> reg[wa3] <= wd3; wa3=15 writes are silently dropped.
REQ-022 Read: rd1/rd2 combinational; address 15 returns r15, otherwise reg[ra].
REQ-023 No write-to-read bypass: a write is visible on rd1/rd2 starting the cycle after the write edge.
REQ-024 Dump FSM states: IDLE, LOAD, SEND, DONE.
REQ-025 IDLE: dump_start=1 at edge -> LOAD, idx <= 0; otherwise stay.
REQ-026 LOAD: capture dump_data <= (idx==15 ? r15 : reg[idx]) -> SEND; dump_valid=0 in LOAD.
REQ-027 SEND: dump_valid=1; dump_data and dump_idx held stable until dump_valid&dump_ready at an edge.
REQ-028 SEND accepted with idx<15 -> idx <= idx+1, go to LOAD; accepted with idx==15 -> DONE.
REQ-029 DONE: dump_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-030 Minimum beat latency is 2 cycles (LOAD + SEND); a full dump takes at least 1 + 32 + 1 cycles from the dump_start edge to returning to IDLE.
REQ-031 dump_start while busy is ignored, with no queuing.
REQ-032 A write to reg[idx] in the same edge as LOAD: dump_data captures the pre-write value; later writes never alter a captured beat.
REQ-033 Register writes and port reads operate normally throughout a dump, with no stall.
REQ-034 dump_busy=1 in LOAD, SEND and DONE.

Reset
REQ-035 reset=0 at edge: R0-R14 <= 0, FSM <= IDLE, idx <= 0, dump_data <= 0; reset has priority over write and dump.
REQ-036 Outputs after reset: dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0, dump_data=0; rd1/rd2 = 0 for addresses 0-14.
REQ-037 Reset asserted mid-dump aborts the sequence with no dump_done pulse; the next dump restarts at idx 0.

Verification
REQ-038 Reset then write R3=0xDEADBEEF, ra1=3 -> rd1=0 in the write cycle, rd1=0xDEADBEEF in the next cycle.
REQ-039 we3=1, wa3=15, wd3=0x1234, r15=0x00000108, ra2=15 -> rd2=0x00000108; stored state unchanged.
REQ-040 Load Rn=n*0x11 for n=0-14, r15=0xF0, dump_start with dump_ready held 1 -> 16 beats idx 0..15, data n*0x11 then 0xF0, dump_done at cycle 34 after the start edge.
REQ-041 Dump with dump_ready low for 5 cycles on beat 4 -> dump_valid, idx=4 and data stable for all 5 cycles; no skipped or repeated index.
REQ-042 Write R2=0xAAAA in the same edge that LOAD captures idx 2 -> beat 2 data is the old value; rd1 (ra1=2) = 0xAAAA the next cycle.
REQ-043 reset low during beat 7 -> next cycle dump_busy=0, dump_valid=0, no dump_done, all registers 0; a new dump_start begins at idx 0.
